// File: rtl/mem_access_if.sv
// Request/response handshake plus the byte-addressed data memory port, as seen by
// the load/store unit (master) and by its environment (slave).
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_write;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_addr, mem_wdata, mem_write
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: validates a MEM-stage request, drives the data
// memory port, extends load data and returns one response per accepted request.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  op_q;
  logic [2:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [2:0]  size;
  logic        illegal, misal, oor, acc_err;

  // 33-bit end address so addr near 2^32 cannot wrap into range
  always_comb begin
    size = 3'd1;
    case (bus.req_op[1:0])
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd1;
    endcase
    illegal = (bus.req_op == 3'b011) || (bus.req_op[2:1] == 2'b11) ||
              (bus.req_op[2] && bus.req_we);
    misal   = (bus.req_op[1:0] == 2'b01 && bus.req_addr[0]) ||
              (bus.req_op[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    oor     = ({1'b0, bus.req_addr} + {30'd0, size}) > 33'(MEM_BYTES);
    acc_err = illegal || misal || oor;
  end

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign bus.busy = !bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      op_q           <= 3'd0;
      cnt            <= 3'd0;
      rdata_q        <= 32'd0;
      err_q          <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
      bus.mem_write  <= 2'b00;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q          <= bus.req_we;
            op_q          <= bus.req_op;
            cnt           <= 3'(RD_LAT - 1);
            rdata_q       <= 32'd0;
            err_q         <= acc_err;
            bus.req_ready <= 1'b0;
            if (acc_err) begin
              state <= RESP;
            end else begin
              bus.mem_addr <= bus.req_addr;
              state        <= ISSUE;
              if (bus.req_we) begin
                bus.mem_wdata <= bus.req_wdata;
                bus.mem_write <= (size == 3'd4) ? 2'b01 :
                                 (size == 3'd2) ? 2'b10 : 2'b11;
              end
            end
          end
        end
        ISSUE, WAIT: begin
          if (we_q) begin
            bus.mem_write <= 2'b00;
            state         <= RESP;
          end else if (cnt == 3'd0) begin
            rdata_q <= extend(op_q, bus.mem_rdata);
            state   <= RESP;
          end else begin
            cnt   <= cnt - 3'd1;
            state <= WAIT;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= rdata_q;
          bus.resp_err   <= err_q;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a byte-array memory with read latency drives
// the DUT, and a transaction-level model predicts every response and memory cycle.
module tb_mem_access_unit;
  localparam int MEM_BYTES = 1024;
  localparam int RD_LAT    = 3;

  logic clk, rst;
  mem_access_if bus();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Memory the DUT talks to: writes on mem_write, read data reflects the address
  // seen RD_LAT-1 edges earlier, so an early capture sees a stale word.
  logic [7:0]  bmem [MEM_BYTES];
  logic        bfilled = 1'b0;
  logic [31:0] p0, p1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (!bfilled) for (int i = 0; i < MEM_BYTES; i++) bmem[i] <= init_byte(i);
      bfilled <= 1'b1;
    end else if (bus.mem_write != 2'b00) begin
      case (bus.mem_write)
        2'b01: for (int i = 0; i < 4; i++) bmem[(bus.mem_addr + i) % MEM_BYTES] <= bus.mem_wdata[8*i +: 8];
        2'b10: for (int i = 0; i < 2; i++) bmem[(bus.mem_addr + i) % MEM_BYTES] <= bus.mem_wdata[8*i +: 8];
        default: bmem[bus.mem_addr % MEM_BYTES] <= bus.mem_wdata[7:0];
      endcase
    end
  end
  always @(posedge clk) begin
    p0 <= bus.mem_addr;
    p1 <= p0;
  end
  assign bus.mem_rdata = {bmem[(p1 + 3) % MEM_BYTES], bmem[(p1 + 2) % MEM_BYTES],
                          bmem[(p1 + 1) % MEM_BYTES], bmem[p1 % MEM_BYTES]};

  // ---------------- reference model ----------------
  logic [7:0] refm [MEM_BYTES];
  logic       rfilled = 1'b0;

  function automatic int sz_of(input logic [2:0] op);
    return (op == 3'd2) ? 4 : (op == 3'd1 || op == 3'd5) ? 2 : 1;
  endfunction

  function automatic bit is_err(input logic we, input logic [2:0] op, input logic [31:0] a);
    int    sz  = sz_of(op);
    bit    ill = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (we && op >= 3'd4);
    bit    mis = (sz == 2 && a % 2 != 0) || (sz == 4 && a % 4 != 0);
    longint e  = longint'(a) + longint'(sz);
    return ill || mis || (e > longint'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] ld_val(input logic [2:0] op, input logic [31:0] a);
    int b0 = int'(refm[a]);
    int v;
    case (op)
      3'd0: v = (b0 >= 128) ? b0 - 256 : b0;
      3'd4: v = b0;
      3'd1: begin v = b0 + 256 * int'(refm[a + 1]); if (v >= 32768) v = v - 65536; end
      3'd5: v = b0 + 256 * int'(refm[a + 1]);
      default: v = b0 + 256 * int'(refm[a + 1]) + 65536 * int'(refm[a + 2])
                   + 16777216 * int'(refm[a + 3]);
    endcase
    return 32'(v);
  endfunction

  int          cyc, acc_cyc, due, ex_sz;
  bit          pend, st, ld, ex_err;
  logic [31:0] ex_rdata, ex_addr, ex_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc  <= 0;
      pend <= 1'b0;
      if (!rfilled) for (int i = 0; i < MEM_BYTES; i++) refm[i] <= init_byte(i);
      rfilled <= 1'b1;
    end else begin
      cyc <= cyc + 1;
      // a store becomes architecturally visible when it is answered
      if (pend && st && cyc + 1 == due)
        for (int i = 0; i < ex_sz; i++) refm[ex_addr + i] <= ex_wdata[8*i +: 8];
      if (bus.req_valid && bus.req_ready) begin
        pend     <= 1'b1;
        acc_cyc  <= cyc + 1;
        ex_err   <= is_err(bus.req_we, bus.req_op, bus.req_addr);
        st       <= bus.req_we && !is_err(bus.req_we, bus.req_op, bus.req_addr);
        ld       <= !bus.req_we && !is_err(bus.req_we, bus.req_op, bus.req_addr);
        due      <= cyc + 1 + (is_err(bus.req_we, bus.req_op, bus.req_addr) ? 1 :
                               bus.req_we ? 2 : RD_LAT + 1);
        ex_rdata <= (is_err(bus.req_we, bus.req_op, bus.req_addr) || bus.req_we) ? 32'd0 :
                    ld_val(bus.req_op, bus.req_addr);
        ex_addr  <= bus.req_addr;
        ex_wdata <= bus.req_wdata;
        ex_sz    <= sz_of(bus.req_op);
      end
    end
  end

  // ---------------- compare process ----------------
  int          n_vec = 0, n_mis = 0;
  bit          lit_en = 1'b0, lit_rd_en = 1'b0, lit_err = 1'b0, tmo_flag = 1'b0;
  logic [31:0] lit_rdata = 32'd0;
  int          lit_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always begin
    @(negedge clk or posedge rst);
    if (rst) begin
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    end else begin
      chk("req_ready", 32'(bus.req_ready), 32'(!pend || cyc >= due));
      chk("busy", 32'(bus.busy), 32'(pend && cyc < due));
      chk("resp_valid", 32'(bus.resp_valid), 32'(pend && cyc == due));
      if (pend && cyc == due) begin
        chk("resp_rdata", bus.resp_rdata, ex_rdata);
        chk("resp_err", 32'(bus.resp_err), 32'(ex_err));
        if (lit_en) begin
          chk("lit_latency", 32'(cyc - acc_cyc), 32'(lit_lat));
          chk("lit_err", 32'(bus.resp_err), 32'(lit_err));
          if (lit_rd_en) chk("lit_rdata", bus.resp_rdata, lit_rdata);
        end
      end
      if (pend && st && cyc == acc_cyc) begin
        chk("mem_write", 32'(bus.mem_write), (ex_sz == 4) ? 32'd1 : (ex_sz == 2) ? 32'd2 : 32'd3);
        chk("st_mem_addr", bus.mem_addr, ex_addr);
        chk("st_mem_wdata", bus.mem_wdata, ex_wdata);
      end else begin
        chk("mem_write_idle", 32'(bus.mem_write), 32'd0);
      end
      if (pend && ld && cyc >= acc_cyc && cyc < acc_cyc + RD_LAT)
        chk("ld_mem_addr", bus.mem_addr, ex_addr);
      if (tmo_flag) chk("wait_bound", 32'd1, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic rand_fields();
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_op    = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: bus.req_addr = 32'($urandom_range(0, MEM_BYTES - 1));
      1: bus.req_addr = 32'(MEM_BYTES - $urandom_range(1, 8));
      2: bus.req_addr = 32'($urandom_range(0, 15));
      default: bus.req_addr = $urandom;
    endcase
    if ($urandom_range(0, 1) == 1) bus.req_addr[1:0] = 2'b00;
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin tmo_flag = 1'b1; @(negedge clk); #1 tmo_flag = 1'b0; end
  endtask

  task automatic dreq(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit rd_en, input logic [31:0] rdata,
                      input bit err, input int lat);
    int k = 0;
    wait_ready();
    lit_en = 1'b1; lit_rd_en = rd_en; lit_rdata = rdata; lit_err = err; lit_lat = lat;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rand_fields();
    while (!bus.resp_valid && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) begin tmo_flag = 1'b1; @(negedge clk); #1 tmo_flag = 1'b0; end
    #1 lit_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    #2 rst = 1'b1;
    #20;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    dreq(1'b1, 3'd2, 32'h10, 32'h8765_4321, 1'b1, 32'h0, 1'b0, 2);
    dreq(1'b0, 3'd2, 32'h10, 32'h0,         1'b1, 32'h8765_4321, 1'b0, RD_LAT + 1);
    dreq(1'b1, 3'd0, 32'h21, 32'h0000_00F0, 1'b1, 32'h0, 1'b0, 2);
    dreq(1'b0, 3'd0, 32'h21, 32'h0,         1'b1, 32'hFFFF_FFF0, 1'b0, RD_LAT + 1);
    dreq(1'b0, 3'd4, 32'h21, 32'h0,         1'b1, 32'h0000_00F0, 1'b0, RD_LAT + 1);
    dreq(1'b1, 3'd1, 32'h30, 32'h0000_8001, 1'b1, 32'h0, 1'b0, 2);
    dreq(1'b0, 3'd1, 32'h30, 32'h0,         1'b1, 32'hFFFF_8001, 1'b0, RD_LAT + 1);
    dreq(1'b0, 3'd5, 32'h30, 32'h0,         1'b1, 32'h0000_8001, 1'b0, RD_LAT + 1);
    dreq(1'b0, 3'd2, 32'h12, 32'h0,         1'b1, 32'h0, 1'b1, 1);
    dreq(1'b1, 3'd1, 32'h3FF, 32'h1234,     1'b1, 32'h0, 1'b1, 1);
    dreq(1'b0, 3'd3, 32'h40, 32'h0,         1'b1, 32'h0, 1'b1, 1);
    dreq(1'b1, 3'd4, 32'h40, 32'h55,        1'b1, 32'h0, 1'b1, 1);
    dreq(1'b0, 3'd0, 32'h3FF, 32'h0,        1'b0, 32'h0, 1'b0, RD_LAT + 1);
    dreq(1'b0, 3'd2, 32'h3FC, 32'h0,        1'b0, 32'h0, 1'b0, RD_LAT + 1);
    dreq(1'b0, 3'd2, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, RD_LAT + 1);
    dreq(1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0,  1'b1, 32'h0, 1'b1, 1);

    // three back-to-back loads with req_valid held high
    wait_ready();
    lit_en = 1'b1; lit_rd_en = 1'b1; lit_rdata = 32'h8765_4321; lit_err = 1'b0; lit_lat = RD_LAT + 1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_op = 3'd2;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    repeat (3 * (RD_LAT + 2)) @(negedge clk);
    bus.req_valid = 1'b0;
    #1 lit_en = 1'b0;

    // reset during a store issue cycle: no write, no response
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_op = 3'd2;
    bus.req_addr = 32'h200; bus.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (8) @(negedge clk);
    dreq(1'b0, 3'd2, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0, RD_LAT + 1);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rand_fields();
      bus.req_valid = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk) bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
